// File: rtl/mips_core_pkg.sv
// ============================================================================
// Module  : mips_core_pkg
// Purpose : Shared sizing constants and the store-queue entry layout used by
//           store_commit_queue.
// Contents: SQ_DEPTH / SQ_DEPTH_BITS   - store queue geometry
//           ROB_DEPTH_BITS, ADDR_WIDTH, DATA_WIDTH - field widths
//           sq_entry_t                 - {valid, committed, tag, addr, data}
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_core_pkg;

    localparam int SQ_DEPTH       = 8;
    localparam int SQ_DEPTH_BITS  = $clog2(SQ_DEPTH);
    localparam int ROB_DEPTH_BITS = 4;
    localparam int ADDR_WIDTH     = 32;
    localparam int DATA_WIDTH     = 32;

    typedef struct packed {
        logic                      valid;
        logic                      committed;
        logic [ROB_DEPTH_BITS-1:0] tag;
        logic [ADDR_WIDTH-1:0]     addr;
        logic [DATA_WIDTH-1:0]     data;
    } sq_entry_t;

endpackage

`default_nettype wire

// File: rtl/store_commit_queue.sv
// ============================================================================
// Module  : store_commit_queue
// Purpose : Holds resolved stores until the ROB retires them, then drains
//           them in program order to the data-cache write port. Also answers
//           the load-ordering query (word-address match on any held store).
// Ports   : clk, rst (async, active-high)
//           st_valid/st_tag/st_addr/st_data  - store allocation
//           sq_full, sq_count                - occupancy
//           commit_valid/commit_tag, commit_ready - ROB retirement handshake
//           flush                            - discard uncommitted stores
//           mem_stall, ld_issue              - block the cache write this cycle
//           ld_addr, ld_match                - load-ordering query
//           mem_wr_en/mem_wr_addr/mem_wr_data - cache write of the head entry
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module store_commit_queue
    import mips_core_pkg::*;
#(
    // Entry layout comes from the package; these must agree with it.
    parameter int SQ_DEPTH       = mips_core_pkg::SQ_DEPTH,
    parameter int ROB_DEPTH_BITS = mips_core_pkg::ROB_DEPTH_BITS,
    parameter int ADDR_WIDTH     = mips_core_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH     = mips_core_pkg::DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          st_valid,
    input  logic [ROB_DEPTH_BITS-1:0]     st_tag,
    input  logic [ADDR_WIDTH-1:0]         st_addr,
    input  logic [DATA_WIDTH-1:0]         st_data,
    output logic                          sq_full,
    output logic [$clog2(SQ_DEPTH):0]     sq_count,
    input  logic                          commit_valid,
    input  logic [ROB_DEPTH_BITS-1:0]     commit_tag,
    output logic                          commit_ready,
    input  logic                          flush,
    input  logic                          mem_stall,
    input  logic                          ld_issue,
    input  logic [ADDR_WIDTH-1:0]         ld_addr,
    output logic                          ld_match,
    output logic                          mem_wr_en,
    output logic [ADDR_WIDTH-1:0]         mem_wr_addr,
    output logic [DATA_WIDTH-1:0]         mem_wr_data
);

    localparam int IDX_W = $clog2(SQ_DEPTH);
    localparam int PTR_W = IDX_W + 1;   // extra wrap bit separates full from empty

    // Word-granular compare: byte offset bits are ignored.
    function automatic logic word_match(input logic [ADDR_WIDTH-1:0] a,
                                        input logic [ADDR_WIDTH-1:0] b);
        return a[ADDR_WIDTH-1:2] == b[ADDR_WIDTH-1:2];
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] head_q, head_d;   // oldest entry, drained next
    logic [PTR_W-1:0] cptr_q, cptr_d;   // oldest uncommitted entry
    logic [PTR_W-1:0] tail_q, tail_d;   // next free slot
    sq_entry_t        ent_q [SQ_DEPTH];
    sq_entry_t        ent_d [SQ_DEPTH];

    logic [IDX_W-1:0] w_head_idx;
    logic [IDX_W-1:0] w_cptr_idx;
    logic [IDX_W-1:0] w_tail_idx;
    logic [PTR_W-1:0] w_count;
    logic             w_alloc;
    logic             w_commit;
    logic [PTR_W-1:0] w_cptr_new;
    logic [PTR_W-1:0] w_live;           // uncommitted entries killed by a flush
    logic [IDX_W-1:0] w_rel;

    assign w_head_idx = head_q[IDX_W-1:0];
    assign w_cptr_idx = cptr_q[IDX_W-1:0];
    assign w_tail_idx = tail_q[IDX_W-1:0];
    assign w_count    = tail_q - head_q;

    // ------------------------------------------------------------------
    // Outputs: combinational from registered state and current inputs
    // ------------------------------------------------------------------
    assign sq_count = w_count;
    assign sq_full  = (w_count == PTR_W'(SQ_DEPTH));

    assign commit_ready = (cptr_q != tail_q) && ent_q[w_cptr_idx].valid &&
                          (ent_q[w_cptr_idx].tag == commit_tag);

    assign mem_wr_en   = ent_q[w_head_idx].valid && ent_q[w_head_idx].committed &&
                         !mem_stall && !ld_issue;
    assign mem_wr_addr = mem_wr_en ? ent_q[w_head_idx].addr : '0;
    assign mem_wr_data = mem_wr_en ? ent_q[w_head_idx].data : '0;

    always_comb begin
        ld_match = 1'b0;
        for (int i = 0; i < SQ_DEPTH; i++) begin
            if (ent_q[i].valid && word_match(ent_q[i].addr, ld_addr)) begin
                ld_match = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    assign w_alloc    = st_valid && !sq_full && !flush;
    assign w_commit   = commit_valid && commit_ready;
    // Commit takes effect before flush, so a store retiring in the flush
    // cycle is already on the surviving side of the boundary.
    assign w_cptr_new = cptr_q + PTR_W'(w_commit);
    assign w_live     = tail_q - w_cptr_new;

    always_comb begin
        head_d = head_q;
        cptr_d = w_cptr_new;
        tail_d = tail_q;
        w_rel  = '0;
        for (int i = 0; i < SQ_DEPTH; i++) begin
            ent_d[i] = ent_q[i];
        end

        if (w_commit) begin
            ent_d[w_cptr_idx].committed = 1'b1;
        end

        // Drained entries are always committed, so they never overlap the
        // flushed range or the allocation slot.
        if (mem_wr_en) begin
            ent_d[w_head_idx] = '0;
            head_d            = head_q + PTR_W'(1);
        end

        if (flush) begin
            for (int i = 0; i < SQ_DEPTH; i++) begin
                w_rel = IDX_W'(i) - w_cptr_new[IDX_W-1:0];
                if ({1'b0, w_rel} < w_live) begin
                    ent_d[i] = '0;
                end
            end
            tail_d = w_cptr_new;
        end else if (w_alloc) begin
            ent_d[w_tail_idx].valid     = 1'b1;
            ent_d[w_tail_idx].committed = 1'b0;
            ent_d[w_tail_idx].tag       = st_tag;
            ent_d[w_tail_idx].addr      = st_addr;
            ent_d[w_tail_idx].data      = st_data;
            tail_d                      = tail_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            cptr_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < SQ_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            cptr_q <= cptr_d;
            tail_q <= tail_d;
            for (int i = 0; i < SQ_DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_store_commit_queue.sv
// ============================================================================
// Module  : tb_store_commit_queue
// Purpose : Self-checking bench for store_commit_queue. A program-order queue
//           model predicts every output each cycle; directed sequences add
//           hand-computed literal expectations.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_store_commit_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic [3:0]  st_tag;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        sq_full;
    logic [3:0]  sq_count;
    logic        commit_valid;
    logic [3:0]  commit_tag;
    logic        commit_ready;
    logic        flush;
    logic        mem_stall;
    logic        ld_issue;
    logic [31:0] ld_addr;
    logic        ld_match;
    logic        mem_wr_en;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;

    always #5 clk = ~clk;

    store_commit_queue dut (
        .clk          (clk),
        .rst          (rst),
        .st_valid     (st_valid),
        .st_tag       (st_tag),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .sq_full      (sq_full),
        .sq_count     (sq_count),
        .commit_valid (commit_valid),
        .commit_tag   (commit_tag),
        .commit_ready (commit_ready),
        .flush        (flush),
        .mem_stall    (mem_stall),
        .ld_issue     (ld_issue),
        .ld_addr      (ld_addr),
        .ld_match     (ld_match),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: stores in program order; the first ncom of them are committed.
    // ------------------------------------------------------------------
    typedef struct {
        logic [3:0]  tag;
        logic [31:0] addr;
        logic [31:0] data;
    } mst_t;

    mst_t mq[$];
    int   ncom = 0;

    function automatic logic m_ready();
        return (ncom < mq.size()) && (mq[ncom].tag == commit_tag);
    endfunction

    function automatic logic m_wr();
        return (ncom > 0) && !mem_stall && !ld_issue;
    endfunction

    function automatic logic m_match();
        logic r = 1'b0;
        foreach (mq[i]) if (mq[i].addr[31:2] == ld_addr[31:2]) r = 1'b1;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        mst_t t;
        logic was_full, rdy, wr;
        if (rst) begin
            mq.delete();
            ncom = 0;
        end else begin
            was_full = (mq.size() == 8);
            rdy      = m_ready();
            wr       = m_wr();
            if (commit_valid && rdy) ncom++;
            if (wr) begin
                t = mq.pop_front();
                ncom--;
            end
            if (flush) begin
                while (mq.size() > ncom) t = mq.pop_back();
            end else if (st_valid && !was_full) begin
                t.tag = st_tag; t.addr = st_addr; t.data = st_data;
                mq.push_back(t);
            end
        end
    end

    // Per-cycle comparison away from the active edge.
    always @(negedge clk) begin
        logic wr;
        wr = m_wr();
        chk("cyc_count",  64'(sq_count),     64'(mq.size()));
        chk("cyc_full",   64'(sq_full),      64'(mq.size() == 8));
        chk("cyc_ready",  64'(commit_ready), 64'(m_ready()));
        chk("cyc_wr_en",  64'(mem_wr_en),    64'(wr));
        chk("cyc_wr_addr", 64'(mem_wr_addr), wr ? 64'(mq[0].addr) : 64'd0);
        chk("cyc_wr_data", 64'(mem_wr_data), wr ? 64'(mq[0].data) : 64'd0);
        chk("cyc_match",  64'(ld_match),     64'(m_match()));
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        st_valid = 0; st_tag = 0; st_addr = 0; st_data = 0;
        commit_valid = 0; commit_tag = 0; flush = 0;
        mem_stall = 0; ld_issue = 0; ld_addr = 0;
    endtask

    task automatic put(input logic [3:0] tg, input logic [31:0] a, input logic [31:0] d);
        st_valid = 1; st_tag = tg; st_addr = a; st_data = d;
        cyc();
        st_valid = 0;
    endtask

    task automatic wait_empty(input string nm);
        for (int k = 0; k < 30 && sq_count != 0; k++) cyc();
        chk(nm, 64'(sq_count), 64'd0);
    endtask

    initial begin
        rst = 1;
        quiet();
        #12;
        chk("rst_count",  64'(sq_count),  64'd0);
        chk("rst_full",   64'(sq_full),   64'd0);
        chk("rst_wr_en",  64'(mem_wr_en), 64'd0);
        chk("rst_match",  64'(ld_match),  64'd0);
        cyc();
        rst = 0;
        cyc();

        // Basic alloc -> commit -> drain
        put(4'd3, 32'h100, 32'hAA);
        commit_valid = 1; commit_tag = 4'd3;
        #1;
        chk("basic_ready", 64'(commit_ready), 64'd1);
        chk("basic_cnt1",  64'(sq_count),     64'd1);
        chk("basic_nowr",  64'(mem_wr_en),    64'd0);
        cyc();
        commit_valid = 0;
        #1;
        chk("basic_wr",    64'(mem_wr_en),   64'd1);
        chk("basic_addr",  64'(mem_wr_addr), 64'h100);
        chk("basic_data",  64'(mem_wr_data), 64'hAA);
        cyc();
        chk("basic_cnt0",  64'(sq_count),    64'd0);

        // Fill, overflow, drain, wrap, refill
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++)
                put(4'(r * 8 + i), 32'h200 + 32'(4 * i), 32'(16 * r + i));
            chk("full_flag", 64'(sq_full),  64'd1);
            chk("full_cnt",  64'(sq_count), 64'd8);
            st_valid = 1; st_tag = 4'hF; st_addr = 32'h2F0; st_data = 32'hDEAD;
            cyc();
            st_valid = 0;
            chk("ovf_dropped", 64'(sq_count), 64'd8);
            for (int i = 0; i < 8; i++) begin
                commit_valid = 1; commit_tag = 4'(r * 8 + i);
                cyc();
            end
            commit_valid = 0;
            wait_empty("fill_drain");
        end

        // Flush after one commit (stall keeps the committed store resident)
        mem_stall = 1;
        put(4'd1, 32'h300, 32'h11);
        put(4'd2, 32'h304, 32'h22);
        put(4'd3, 32'h308, 32'h33);
        commit_valid = 1; commit_tag = 4'd1;
        cyc();
        commit_valid = 0; flush = 1;
        st_valid = 1; st_tag = 4'd9; st_addr = 32'h30C; st_data = 32'h99;
        cyc();
        flush = 0; st_valid = 0;
        chk("flush_cnt", 64'(sq_count), 64'd1);
        commit_valid = 1; commit_tag = 4'd2;
        #1;
        chk("flush_noready", 64'(commit_ready), 64'd0);
        commit_valid = 0; mem_stall = 0;
        #1;
        chk("flush_wr",   64'(mem_wr_en),   64'd1);
        chk("flush_addr", 64'(mem_wr_addr), 64'h300);
        cyc();
        chk("flush_empty", 64'(sq_count), 64'd0);

        // Commit in the flush cycle survives
        mem_stall = 1;
        put(4'd4, 32'h310, 32'h44);
        put(4'd5, 32'h314, 32'h55);
        commit_valid = 1; commit_tag = 4'd4; flush = 1;
        cyc();
        commit_valid = 0; flush = 0;
        chk("cflush_cnt", 64'(sq_count), 64'd1);
        mem_stall = 0;
        #1;
        chk("cflush_addr", 64'(mem_wr_addr), 64'h310);
        cyc();
        chk("cflush_empty", 64'(sq_count), 64'd0);

        // Drain blocked by ld_issue then mem_stall
        put(4'd5, 32'h400, 32'h77);
        commit_valid = 1; commit_tag = 4'd5;
        cyc();
        commit_valid = 0; ld_issue = 1;
        #1;
        chk("ldi_block1", 64'(mem_wr_en), 64'd0);
        cyc();
        chk("ldi_block2", 64'(mem_wr_en), 64'd0);
        cyc();
        ld_issue = 0; mem_stall = 1;
        #1;
        chk("stall_block", 64'(mem_wr_en), 64'd0);
        cyc();
        mem_stall = 0;
        #1;
        chk("unblock_wr",   64'(mem_wr_en),   64'd1);
        chk("unblock_data", 64'(mem_wr_data), 64'h77);
        cyc();
        chk("unblock_empty", 64'(sq_count), 64'd0);

        // Load-address match
        put(4'd6, 32'h104, 32'h66);
        ld_addr = 32'h106;
        #1;
        chk("ldm_same_word", 64'(ld_match), 64'd1);
        ld_addr = 32'h108;
        #1;
        chk("ldm_next_word", 64'(ld_match), 64'd0);
        commit_valid = 1; commit_tag = 4'd6;
        cyc();
        commit_valid = 0;
        cyc();
        ld_addr = 32'h106;
        #1;
        chk("ldm_after_drain", 64'(ld_match), 64'd0);
        ld_addr = 0;

        // Async reset mid-drain
        mem_stall = 1;
        for (int i = 0; i < 4; i++) put(4'(i), 32'h500 + 32'(4 * i), 32'(i + 1));
        commit_valid = 1; commit_tag = 4'd0;
        cyc();
        commit_tag = 4'd1;
        cyc();
        commit_valid = 0; mem_stall = 0;
        cyc();
        commit_valid = 1; commit_tag = 4'd2; ld_addr = 32'h508;
        #1;
        chk("pre_rst_wr",    64'(mem_wr_addr),  64'h504);
        chk("pre_rst_ready", 64'(commit_ready), 64'd1);
        chk("pre_rst_match", 64'(ld_match),     64'd1);
        rst = 1;
        #1;
        chk("arst_count", 64'(sq_count),     64'd0);
        chk("arst_ready", 64'(commit_ready), 64'd0);
        chk("arst_wr",    64'(mem_wr_en),    64'd0);
        chk("arst_addr",  64'(mem_wr_addr),  64'd0);
        chk("arst_data",  64'(mem_wr_data),  64'd0);
        chk("arst_match", 64'(ld_match),     64'd0);
        quiet();
        cyc();
        rst = 0;
        cyc();
        chk("post_rst_cnt", 64'(sq_count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/store_commit_queue.md
# store_commit_queue

Holds resolved stores issued by the memory reservation station until the ROB retires them, then drains them in program order to the data-cache port. It sits between the memory reservation station (producer of address+data for stores) and the d-cache input mux (consumer of `mem_wr_*`). It also answers the reservation station's load-ordering query: does any in-flight store match a load address.

## Interface
- `SQ_DEPTH`, 8: entries; power of two, ≥2
- `ROB_DEPTH_BITS`, 4: ROB tag width
- `ADDR_WIDTH`, 32: byte address width
- `DATA_WIDTH`, 32: store data width

Ports:
- `clk` in 1: single clock
- `rst` in 1: reset, asynchronous, active-high
- `st_valid` in 1: resolved store presented this cycle
- `st_tag` in ROB_DEPTH_BITS: ROB tag of store
- `st_addr` in ADDR_WIDTH: effective address
- `st_data` in DATA_WIDTH: store data
- `sq_full` out 1: no free entry
- `sq_count` out $clog2(SQ_DEPTH)+1: occupied entries
- `commit_valid` in 1: ROB head is a store retiring this cycle
- `commit_tag` in ROB_DEPTH_BITS: its tag
- `commit_ready` out 1: oldest pending entry exists and tag == `commit_tag`
- `flush` in 1: branch-mispredict flush
- `mem_stall` in 1: memory-stage stall
- `ld_issue` in 1: a load takes the cache port this cycle
- `ld_addr` in ADDR_WIDTH: load address to check
- `ld_match` out 1: word-address match against any valid entry
- `mem_wr_en` out 1: store write to cache this cycle
- `mem_wr_addr` out ADDR_WIDTH, `mem_wr_data` out DATA_WIDTH: head entry address/data

## Operation
- Circular buffer, three pointers with extra wrap bit: `head` (oldest, drained next), `cptr` (oldest uncommitted), `tail` (next free). Invariant: head ≤ cptr ≤ tail in circular order.
- Entry: valid, committed, tag, addr, data.
- Allocate: `st_valid & !sq_full & !flush` → write at `tail`, committed=0, tail++. `st_valid` while full: dropped, no state change.
- Commit: `commit_valid & commit_ready` → entry[cptr].committed=1, cptr++. `commit_valid` without ready: ignored.
- Drain: `mem_wr_en = entry[head].valid & entry[head].committed & !mem_stall & !ld_issue`; `mem_wr_addr/data` = entry[head] fields, driven to 0 when `mem_wr_en`=0. On edge with `mem_wr_en`: clear entry, head++.
- Flush: entries from cptr to tail-1 cleared, tail ← cptr. Committed entries survive and keep draining.
- `ld_match` = OR over valid entries of `addr[ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2]`; pending and committed entries both count.
- `sq_full` = (tail−head) == SQ_DEPTH; `sq_count` = tail−head; both from registered state, no same-cycle bypass of a drain.

## Timing
- Reset (async): all entries invalid, pointers 0; `sq_full`=0, `sq_count`=0, `commit_ready`=0, `mem_wr_en`=0, `ld_match`=0, `mem_wr_addr/data`=0.
- All outputs combinational from registered state plus current inputs; zero latency. Entry allocated at edge N is visible to `ld_match`/`commit_ready` in cycle N+1, drainable in N+2 at the earliest (commit in N+1).
- Same cycle: allocate+commit+drain all apply. Commit before flush: an entry committed in the flush cycle survives. Allocate in a flush cycle is dropped. Drain in a flush cycle proceeds.
- Full + drain same cycle: `st_valid` still dropped.
- Pointer wrap: index = low bits, wrap bit distinguishes full from empty.

## Structure
- `mips_core_pkg`: `SQ_DEPTH`, `SQ_DEPTH_BITS`, typedef `sq_entry_t` {valid, committed, tag, addr, data}.
- Single module; address compare is a local function. No sub-module.

## Test plan
- Alloc tag 3 addr 0x100 data 0xAA; commit tag 3 next cycle → `mem_wr_en`=1 with 0x100/0xAA the cycle after, `sq_count` 1→0.
- Fill 8 stores, 9th `st_valid` → `sq_full`=1, 9th dropped; drain all → wrap, re-fill 8 succeeds.
- 3 stores, commit first, `flush` → `sq_count`=1, committed store still drains; `commit_ready`=0 afterwards.
- Committed head with `ld_issue`=1 for 2 cycles, then `mem_stall`=1 for 1 → `mem_wr_en`=0 throughout, then 1 once both drop.
- Pending store at 0x104; `ld_addr`=0x106 → `ld_match`=1; `ld_addr`=0x108 → 0; after drain → 0.
- `rst` asserted mid-drain with 4 entries → all outputs 0 immediately, without waiting for a clock edge.
